// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx serializer among c_NUM_REQ byte producers.
// A grant covers a burst of bytes; each byte is strobed once and the arbiter waits for Tx done.
//
// state | meaning
// IDLE  | no owner; arbitrate once the serializer is not active
// ISSUE | strobe latched byte to uart_tx and acknowledge the owner
// WAIT  | serializer busy; wait for Tx done or abort on timeout
// GAP   | idle spacing after a grant is released
module uart_tx_arbiter #(
    parameter int c_NUM_REQ      = 4,
    parameter int c_MAX_BURST    = 16,
    parameter int c_GAP_CLKS     = 2,
    parameter int c_TIMEOUT_CLKS = 2048
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic [c_NUM_REQ-1:0]   i_Req_DV,
    input  logic [8*c_NUM_REQ-1:0] i_Req_Byte,
    input  logic [c_NUM_REQ-1:0]   i_Req_Last,
    output logic [c_NUM_REQ-1:0]   o_Req_Ready,
    output logic [c_NUM_REQ-1:0]   o_Grant,
    output logic                   o_Tx_DV,
    output logic [7:0]             o_Tx_Byte,
    input  logic                   i_Tx_Active,
    input  logic                   i_Tx_Done,
    output logic                   o_Busy,
    output logic                   o_Timeout
);

    localparam int c_PTR_W   = $clog2(c_NUM_REQ);
    localparam int c_IDX_W   = c_PTR_W + 1;
    localparam int c_TMR_MAX = (c_TIMEOUT_CLKS > c_GAP_CLKS) ? c_TIMEOUT_CLKS : c_GAP_CLKS;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_IDX_W-1:0] c_N_IDX    = c_IDX_W'(c_NUM_REQ);
    localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(c_NUM_REQ - 1);
    localparam logic [7:0]         c_MAX_B    = 8'(c_MAX_BURST);
    // Both timers count down and expire on zero, so loads are (duration - 1).
    localparam logic [c_TMR_W-1:0] c_TO_LOAD  = c_TMR_W'(c_TIMEOUT_CLKS - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LOAD = c_TMR_W'((c_GAP_CLKS == 0) ? 0 : c_GAP_CLKS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} t_State;

    t_State                r_State,   w_State_Next;
    logic [c_NUM_REQ-1:0]  r_Grant,   w_Grant_Next;
    logic [c_PTR_W-1:0]    r_Gnt_Idx, w_Gnt_Idx_Next;
    logic [c_PTR_W-1:0]    r_Ptr,     w_Ptr_Next;
    logic [7:0]            r_Burst,   w_Burst_Next;
    logic                  r_Last,    w_Last_Next;
    logic [c_TMR_W-1:0]    r_Timer,   w_Timer_Next;
    logic                  r_Tx_DV,   w_Tx_DV_Next;
    logic [7:0]            r_Tx_Byte, w_Tx_Byte_Next;
    logic [c_NUM_REQ-1:0]  r_Ready,   w_Ready_Next;
    logic                  r_Busy,    w_Busy_Next;
    logic                  r_Timeout, w_Timeout_Next;

    logic                  w_Found;
    logic [c_PTR_W-1:0]    w_Sel;
    logic [c_IDX_W-1:0]    w_Idx;
    logic [c_NUM_REQ-1:0]  w_Sel_Onehot;
    logic [7:0]            w_Sel_Byte;
    logic [7:0]            w_Gnt_Byte;
    logic [c_PTR_W-1:0]    w_Ptr_Rel;
    logic                  w_Release;

    // First valid requester at or above the pointer, wrapping past the top.
    always_comb begin
        w_Found = 1'b0;
        w_Sel   = '0;
        w_Idx   = '0;
        for (int i = 0; i < c_NUM_REQ; i++) begin
            w_Idx = {1'b0, r_Ptr} + c_IDX_W'(i);
            if (w_Idx >= c_N_IDX) begin
                w_Idx = w_Idx - c_N_IDX;
            end
            if (!w_Found && i_Req_DV[w_Idx[c_PTR_W-1:0]]) begin
                w_Found = 1'b1;
                w_Sel   = w_Idx[c_PTR_W-1:0];
            end
        end
    end

    assign w_Sel_Onehot = {{(c_NUM_REQ-1){1'b0}}, 1'b1} << w_Sel;
    assign w_Sel_Byte   = i_Req_Byte[{w_Sel, 3'b000} +: 8];
    assign w_Gnt_Byte   = i_Req_Byte[{r_Gnt_Idx, 3'b000} +: 8];
    assign w_Ptr_Rel    = (r_Gnt_Idx == c_LAST_IDX) ? '0 : r_Gnt_Idx + 1'b1;

    always_comb begin
        w_State_Next   = r_State;
        w_Grant_Next   = r_Grant;
        w_Gnt_Idx_Next = r_Gnt_Idx;
        w_Ptr_Next     = r_Ptr;
        w_Burst_Next   = r_Burst;
        w_Last_Next    = r_Last;
        w_Timer_Next   = r_Timer;
        w_Tx_Byte_Next = r_Tx_Byte;
        w_Tx_DV_Next   = 1'b0;
        w_Ready_Next   = '0;
        w_Timeout_Next = 1'b0;
        w_Release      = 1'b0;

        case (r_State)
            IDLE: begin
                if (w_Found && !i_Tx_Active) begin
                    w_Grant_Next   = w_Sel_Onehot;
                    w_Gnt_Idx_Next = w_Sel;
                    w_Tx_Byte_Next = w_Sel_Byte;
                    w_Last_Next    = i_Req_Last[w_Sel];
                    w_Burst_Next   = '0;
                    w_Tx_DV_Next   = 1'b1;
                    w_Ready_Next   = w_Sel_Onehot;
                    w_State_Next   = ISSUE;
                end
            end
            ISSUE: begin
                w_Burst_Next = r_Burst + 8'd1;
                w_Timer_Next = c_TO_LOAD;
                w_State_Next = WAIT;
            end
            WAIT: begin
                if (i_Tx_Done) begin
                    if (r_Last || (r_Burst == c_MAX_B) || !i_Req_DV[r_Gnt_Idx]) begin
                        w_Release = 1'b1;
                    end else begin
                        w_Tx_Byte_Next = w_Gnt_Byte;
                        w_Last_Next    = i_Req_Last[r_Gnt_Idx];
                        w_Tx_DV_Next   = 1'b1;
                        w_Ready_Next   = r_Grant;
                        w_State_Next   = ISSUE;
                    end
                end else if (r_Timer == '0) begin
                    w_Timeout_Next = 1'b1;
                    w_Release      = 1'b1;
                end else begin
                    w_Timer_Next = r_Timer - 1'b1;
                end
            end
            GAP: begin
                if (r_Timer == '0) begin
                    w_State_Next = IDLE;
                end else begin
                    w_Timer_Next = r_Timer - 1'b1;
                end
            end
            default: w_State_Next = IDLE;
        endcase

        if (w_Release) begin
            w_Ptr_Next   = w_Ptr_Rel;
            w_Grant_Next = '0;
            w_Timer_Next = c_GAP_LOAD;
            w_State_Next = GAP;
        end

        w_Busy_Next = (w_State_Next != IDLE);
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State   <= IDLE;
            r_Grant   <= '0;
            r_Gnt_Idx <= '0;
            r_Ptr     <= '0;
            r_Burst   <= '0;
            r_Last    <= 1'b0;
            r_Timer   <= '0;
            r_Tx_DV   <= 1'b0;
            r_Tx_Byte <= 8'h00;
            r_Ready   <= '0;
            r_Busy    <= 1'b0;
            r_Timeout <= 1'b0;
        end else begin
            r_State   <= w_State_Next;
            r_Grant   <= w_Grant_Next;
            r_Gnt_Idx <= w_Gnt_Idx_Next;
            r_Ptr     <= w_Ptr_Next;
            r_Burst   <= w_Burst_Next;
            r_Last    <= w_Last_Next;
            r_Timer   <= w_Timer_Next;
            r_Tx_DV   <= w_Tx_DV_Next;
            r_Tx_Byte <= w_Tx_Byte_Next;
            r_Ready   <= w_Ready_Next;
            r_Busy    <= w_Busy_Next;
            r_Timeout <= w_Timeout_Next;
        end
    end

    assign o_Grant     = r_Grant;
    assign o_Req_Ready = r_Ready;
    assign o_Tx_DV     = r_Tx_DV;
    assign o_Tx_Byte   = r_Tx_Byte;
    assign o_Busy      = r_Busy;
    assign o_Timeout   = r_Timeout;

endmodule
